// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RV32I control path:
// FSM states, opcodes, PC/address select codes, ALU and writeback encodings.
package multicycle_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_MULDIV    = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [1:0] NPC_PLUS4    = 2'd0;
  localparam logic [1:0] NPC_PLUS_IMM = 2'd1;
  localparam logic [1:0] NPC_JALR     = 2'd2;

  localparam logic MEM_ADDR_PC  = 1'b0;
  localparam logic MEM_ADDR_ALU = 1'b1;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;

  localparam logic [2:0] WB_ALU    = 3'd0;
  localparam logic [2:0] WB_MEM    = 3'd1;
  localparam logic [2:0] WB_IMM    = 3'd2;
  localparam logic [2:0] WB_PC4    = 3'd3;
  localparam logic [2:0] WB_MULDIV = 3'd4;

  function automatic logic is_known_opcode(input logic [6:0] opcode);
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM:
        is_known_opcode = 1'b1;
      default:
        is_known_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_control.sv
// ALU function decode from opcode/funct3/funct7[5]; branches pick the
// comparison whose zero flag drives the taken decision.
module alu_control
  import multicycle_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_bit5,
  output logic [4:0] alu_function
);

  logic [4:0] arith_function;

  always_comb begin
    arith_function = ALU_ADD;
    case (funct3)
      3'b000: arith_function = ALU_ADD;
      3'b001: arith_function = ALU_SLL;
      3'b010: arith_function = ALU_SLT;
      3'b011: arith_function = ALU_SLTU;
      3'b100: arith_function = ALU_XOR;
      3'b101: arith_function = funct7_bit5 ? ALU_SRA : ALU_SRL;
      3'b110: arith_function = ALU_OR;
      3'b111: arith_function = ALU_AND;
      default: arith_function = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_function = ALU_ADD;
    case (opcode)
      OPC_OP:     alu_function = (funct3 == 3'b000 && funct7_bit5) ? ALU_SUB : arith_function;
      OPC_OP_IMM: alu_function = arith_function;
      OPC_BRANCH: begin
        // funct3[2:1]: 00 eq/ne, 10 signed lt/ge, 11 unsigned lt/ge
        case (funct3[2:1])
          2'b10:   alu_function = ALU_SLT;
          2'b11:   alu_function = ALU_SLTU;
          default: alu_function = ALU_SUB;
        endcase
      end
      default:    alu_function = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_transfer.sv
// Resolves the next-PC source: branch condition from the ALU zero flag,
// PC+imm for JAL, register target for JALR, PC+4 otherwise.
module control_transfer
  import multicycle_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       alu_result_equal_zero,
  output logic [1:0] transfer_select
);

  logic branch_taken;

  // SLT/SLTU produce 1 when "less than", so a nonzero result means lt holds.
  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:          branch_taken = alu_result_equal_zero;
      3'b001:          branch_taken = !alu_result_equal_zero;
      3'b100, 3'b110:  branch_taken = !alu_result_equal_zero;
      3'b101, 3'b111:  branch_taken = alu_result_equal_zero;
      default:         branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    transfer_select = NPC_PLUS4;
    case (opcode)
      OPC_BRANCH: transfer_select = branch_taken ? NPC_PLUS_IMM : NPC_PLUS4;
      OPC_JAL:    transfer_select = NPC_PLUS_IMM;
      OPC_JALR:   transfer_select = NPC_JALR;
      default:    transfer_select = NPC_PLUS4;
    endcase
  end

endmodule

// File: rtl/multicycle_fsm.sv
// Instruction sequencer: state register, memory wait counter and strobe decode.
// MULTICYCLE_MULDIV_EN adds the MULDIV state and its start/done handshake.
module multicycle_fsm
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 0,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] inst_opcode,
  input  logic [6:0] inst_funct7,
  input  logic       mem_ready,
  input  logic [1:0] transfer_select,
`ifdef MULTICYCLE_MULDIV_EN
  input  logic       muldiv_done,
  output logic       muldiv_start,
`endif
  output logic       pc_write_enable,
  output logic       ir_write_enable,
  output logic       regfile_write_enable,
  output logic       alu_operand_a_select,
  output logic       alu_operand_b_select,
  output logic       alu_enable,
  output logic       mem_address_select,
  output logic       data_mem_read_enable,
  output logic       data_mem_write_enable,
  output logic [2:0] reg_writeback_select,
  output logic [1:0] next_pc_select,
  output logic       inst_retire,
  output logic       fault
);

  state_t                   state_reg, state_next;
  logic [TIMEOUT_WIDTH-1:0] wait_count_reg, wait_count_next;
  logic [TIMEOUT_WIDTH-1:0] wait_count_inc;
  logic                     timed_out;
  logic                     is_muldiv;

`ifdef MULTICYCLE_MULDIV_EN
  logic muldiv_active_reg;

  // Marks cycles after the first in MULDIV so start is a single pulse.
  always_ff @(posedge clock) begin
    if (reset) muldiv_active_reg <= 1'b0;
    else       muldiv_active_reg <= (state_reg == ST_MULDIV);
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_FETCH;
      wait_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      wait_count_reg <= wait_count_next;
    end
  end

  assign is_muldiv      = (inst_opcode == OPC_OP) && (inst_funct7 == FUNCT7_MULDIV);
  assign wait_count_inc = (wait_count_reg == '1) ? wait_count_reg : wait_count_reg + 1'b1;
  assign timed_out      = (MEM_TIMEOUT != 0) &&
                          (wait_count_reg >= TIMEOUT_WIDTH'(MEM_TIMEOUT));

  always_comb begin
    state_next            = state_reg;
    wait_count_next       = '0;
    pc_write_enable       = 1'b0;
    ir_write_enable       = 1'b0;
    regfile_write_enable  = 1'b0;
    alu_operand_a_select  = 1'b0;
    alu_operand_b_select  = 1'b0;
    alu_enable            = 1'b0;
    mem_address_select    = MEM_ADDR_PC;
    data_mem_read_enable  = 1'b0;
    data_mem_write_enable = 1'b0;
    reg_writeback_select  = WB_ALU;
    next_pc_select        = NPC_PLUS4;
    inst_retire           = 1'b0;
    fault                 = 1'b0;
`ifdef MULTICYCLE_MULDIV_EN
    muldiv_start          = 1'b0;
`endif

    case (state_reg)
      ST_FETCH: begin
        data_mem_read_enable = 1'b1;
        if (mem_ready) begin
          ir_write_enable = 1'b1;
          state_next      = ST_DECODE;
        end else if (timed_out) begin
          state_next = ST_FAULT;
        end else begin
          wait_count_next = wait_count_inc;
        end
      end

      ST_DECODE: begin
        if (!is_known_opcode(inst_opcode)) state_next = ST_FAULT;
`ifndef MULTICYCLE_MULDIV_EN
        else if (is_muldiv)                state_next = ST_FAULT;
`endif
        else                               state_next = ST_EXECUTE;
      end

      ST_EXECUTE: begin
        alu_enable = 1'b1;
        state_next = ST_WRITEBACK;
        case (inst_opcode)
          OPC_AUIPC, OPC_JAL: begin
            alu_operand_a_select = 1'b1;
            alu_operand_b_select = 1'b1;
          end
          OPC_LUI, OPC_JALR, OPC_OP_IMM: alu_operand_b_select = 1'b1;
          OPC_LOAD, OPC_STORE: begin
            alu_operand_b_select = 1'b1;
            state_next           = ST_MEM;
          end
          OPC_BRANCH: begin
            pc_write_enable = 1'b1;
            inst_retire     = 1'b1;
            next_pc_select  = transfer_select;
            state_next      = ST_FETCH;
          end
          OPC_MISC_MEM, OPC_SYSTEM: begin
            pc_write_enable = 1'b1;
            inst_retire     = 1'b1;
            state_next      = ST_FETCH;
          end
`ifdef MULTICYCLE_MULDIV_EN
          OPC_OP: if (is_muldiv) state_next = ST_MULDIV;
`endif
          default: ;
        endcase
      end

      ST_MEM: begin
        mem_address_select    = MEM_ADDR_ALU;
        data_mem_read_enable  = (inst_opcode == OPC_LOAD);
        data_mem_write_enable = (inst_opcode == OPC_STORE);
        if (mem_ready) begin
          if (inst_opcode == OPC_LOAD) begin
            state_next = ST_WRITEBACK;
          end else begin
            pc_write_enable = 1'b1;
            inst_retire     = 1'b1;
            state_next      = ST_FETCH;
          end
        end else if (timed_out) begin
          state_next = ST_FAULT;
        end else begin
          wait_count_next = wait_count_inc;
        end
      end

      ST_WRITEBACK: begin
        regfile_write_enable = 1'b1;
        pc_write_enable      = 1'b1;
        inst_retire          = 1'b1;
        next_pc_select       = transfer_select;
        state_next           = ST_FETCH;
        case (inst_opcode)
          OPC_LUI:           reg_writeback_select = WB_IMM;
          OPC_JAL, OPC_JALR: reg_writeback_select = WB_PC4;
          OPC_LOAD:          reg_writeback_select = WB_MEM;
`ifdef MULTICYCLE_MULDIV_EN
          OPC_OP:            reg_writeback_select = is_muldiv ? WB_MULDIV : WB_ALU;
`endif
          default:           reg_writeback_select = WB_ALU;
        endcase
      end

      ST_MULDIV: begin
`ifdef MULTICYCLE_MULDIV_EN
        muldiv_start = !muldiv_active_reg;
        if (muldiv_done) state_next = ST_WRITEBACK;
`else
        state_next = ST_FAULT;
`endif
      end

      ST_FAULT: fault = 1'b1;

      default: state_next = ST_FAULT;
    endcase

    // A reset cycle must never leak a strobe from the aborted instruction.
    if (reset) begin
      pc_write_enable       = 1'b0;
      ir_write_enable       = 1'b0;
      regfile_write_enable  = 1'b0;
      alu_operand_a_select  = 1'b0;
      alu_operand_b_select  = 1'b0;
      alu_enable            = 1'b0;
      mem_address_select    = MEM_ADDR_PC;
      data_mem_read_enable  = 1'b0;
      data_mem_write_enable = 1'b0;
      reg_writeback_select  = WB_ALU;
      next_pc_select        = NPC_PLUS4;
      inst_retire           = 1'b0;
      fault                 = 1'b0;
`ifdef MULTICYCLE_MULDIV_EN
      muldiv_start          = 1'b0;
`endif
    end
  end

endmodule

// File: rtl/multicycle_ctlpath.sv
// Multicycle RV32I control path top: sequencer plus ALU-function and
// next-PC decode. Define MULTICYCLE_MULDIV_EN for the mul/div handshake.
module multicycle_ctlpath
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 0,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] inst_opcode,
  input  logic [2:0] inst_funct3,
  input  logic [6:0] inst_funct7,
  input  logic       alu_result_equal_zero,
  input  logic       mem_ready,
`ifdef MULTICYCLE_MULDIV_EN
  input  logic       muldiv_done,
  output logic       muldiv_start,
`endif
  output logic       pc_write_enable,
  output logic       ir_write_enable,
  output logic       regfile_write_enable,
  output logic       alu_operand_a_select,
  output logic       alu_operand_b_select,
  output logic       mem_address_select,
  output logic       data_mem_read_enable,
  output logic       data_mem_write_enable,
  output logic [2:0] reg_writeback_select,
  output logic [4:0] alu_function,
  output logic [1:0] next_pc_select,
  output logic       inst_retire,
  output logic       fault
);

  logic [4:0] decoded_alu_function;
  logic [1:0] transfer_select;
  logic       alu_enable;

  alu_control u_alu_control (
    .opcode       (inst_opcode),
    .funct3       (inst_funct3),
    .funct7_bit5  (inst_funct7[5]),
    .alu_function (decoded_alu_function)
  );

  control_transfer u_control_transfer (
    .opcode                (inst_opcode),
    .funct3                (inst_funct3),
    .alu_result_equal_zero (alu_result_equal_zero),
    .transfer_select       (transfer_select)
  );

  multicycle_fsm #(
    .MEM_TIMEOUT   (MEM_TIMEOUT),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_fsm (
    .clock                 (clock),
    .reset                 (reset),
    .inst_opcode           (inst_opcode),
    .inst_funct7           (inst_funct7),
    .mem_ready             (mem_ready),
    .transfer_select       (transfer_select),
`ifdef MULTICYCLE_MULDIV_EN
    .muldiv_done           (muldiv_done),
    .muldiv_start          (muldiv_start),
`endif
    .pc_write_enable       (pc_write_enable),
    .ir_write_enable       (ir_write_enable),
    .regfile_write_enable  (regfile_write_enable),
    .alu_operand_a_select  (alu_operand_a_select),
    .alu_operand_b_select  (alu_operand_b_select),
    .alu_enable            (alu_enable),
    .mem_address_select    (mem_address_select),
    .data_mem_read_enable  (data_mem_read_enable),
    .data_mem_write_enable (data_mem_write_enable),
    .reg_writeback_select  (reg_writeback_select),
    .next_pc_select        (next_pc_select),
    .inst_retire           (inst_retire),
    .fault                 (fault)
  );

  // The ALU function only matters in EXECUTE; elsewhere it rests at ADD.
  assign alu_function = alu_enable ? decoded_alu_function : ALU_ADD;

endmodule

// File: doc/multicycle_ctlpath.md
Name: multicycle_ctlpath

Overview:
Control path for the multicycle RV32I core. It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK with a single shared instruction/data memory port, and stalls on a memory ready handshake. It drives the same datapath select/enable signals as the single-cycle core, plus IR latch, memory address select and retire pulse. A programmable memory timeout and an illegal-opcode check route the core into a sticky FAULT state.

Parameters:
MEM_TIMEOUT, 0, maximum cycles to wait for mem_ready in FETCH or MEM; 0 disables the timeout.
TIMEOUT_WIDTH, 8, width of the wait counter; MEM_TIMEOUT must be less than 2**TIMEOUT_WIDTH.

Ports:
clock  in  1  core clock.
reset  in  1  synchronous, active-high reset.
inst_opcode  in  7  IR[6:0].
inst_funct3  in  3  IR[14:12].
inst_funct7  in  7  IR[31:25].
alu_result_equal_zero  in  1  branch comparison result.
mem_ready  in  1  memory completed the current request this cycle.
pc_write_enable  out  1  PC update strobe.
ir_write_enable  out  1  latch fetched word into IR.
regfile_write_enable  out  1  register file write strobe.
alu_operand_a_select  out  1  0=rs1, 1=PC.
alu_operand_b_select  out  1  0=rs2, 1=immediate.
mem_address_select  out  1  0=PC (fetch), 1=ALU result (data).
data_mem_read_enable  out  1  memory read request (fetch or load).
data_mem_write_enable  out  1  store request.
reg_writeback_select  out  3  ALU / mem / imm / PC+4 / etc. (existing encoding).
alu_function  out  5  existing ALU function encoding.
next_pc_select  out  2  0=PC+4, 1=PC+imm, 2=jalr target.
inst_retire  out  1  one-cycle pulse when an instruction completes.
fault  out  1  sticky; high while in FAULT.

Behaviour:
- Reset: state=FETCH, wait counter=0, fault=0. On reset, all strobes/enables are 0 in the reset cycle. Reset mid-instruction aborts it; no write strobe is issued.
- Strobes are combinational from state and inputs. All datapath selects default to 0 when not used.
- FETCH:
  - mem_address_select=0, data_mem_read_enable=1.
  - On mem_ready: ir_write_enable=1 and go to DECODE. Otherwise stay.
- DECODE:
  - Known opcode (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM): go to EXECUTE.
  - Any other opcode: go to FAULT.
- EXECUTE: ALU selects and alu_function are set per opcode class.
  - BRANCH: pc_write_enable=1 and inst_retire=1. next_pc_select=1 if the funct3 condition holds, else 0. Go to FETCH.
  - MISC-MEM/SYSTEM: treated as NOP. pc_write_enable=1, next_pc_select=0, retire, go to FETCH.
  - LOAD/STORE: compute address, go to MEM.
  - All others: go to WRITEBACK.
- MEM:
  - mem_address_select=1. LOAD asserts data_mem_read_enable; STORE asserts data_mem_write_enable. Requests are held until mem_ready.
  - LOAD on mem_ready: go to WRITEBACK.
  - STORE on mem_ready: pc_write_enable=1, next_pc_select=0, retire, go to FETCH.
- WRITEBACK: regfile_write_enable=1, pc_write_enable=1, inst_retire=1, then go to FETCH.
  - JAL: reg_writeback_select=PC+4, next_pc_select=1.
  - JALR: reg_writeback_select=PC+4, next_pc_select=2.
  - Otherwise: next_pc_select=0.
- Wait counter:
  - Cleared on entry to FETCH/MEM and on mem_ready; increments each waiting cycle, saturating.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT without mem_ready, go to FAULT next cycle.
  - mem_ready in the same cycle the counter reaches MEM_TIMEOUT wins: normal progress, no fault.
- FAULT: fault=1, all strobes 0. Exit only by reset.
- Latency with mem_ready tied high: ALU op/JAL = 4 cycles, branch/NOP = 3, load = 5, store = 4.

Optional Feature:
MULTICYCLE_MULDIV_EN.
- Defined:
  - Adds ports muldiv_start (out, 1) and muldiv_done (in, 1).
  - OP with funct7=0000001 enters a MULDIV state that pulses muldiv_start for one cycle on entry, then waits for muldiv_done.
  - On muldiv_done, go to WRITEBACK with reg_writeback_select=muldiv result.
  - The timeout does not apply in MULDIV.
- Undefined: the ports are absent, and funct7=0000001 on OP causes FAULT.

Decomposition:
- Shared package multicycle_pkg holds:
  - the state enum (FETCH, DECODE, EXECUTE, MEM, WRITEBACK, MULDIV, FAULT);
  - opcode localparams;
  - next_pc_select and mem_address_select encodings.
- Existing constants are reused for the ALU function and writeback encodings.
- One sub-module, multicycle_fsm, holds the state register, wait counter and strobe decode.
- The top instantiates multicycle_fsm plus the existing alu_control and control_transfer blocks.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready=1 → states F,D,E,W; regfile_write_enable and inst_retire in cycle 4; next_pc_select=0.
- LW with mem_ready low 3 cycles in MEM → data_mem_read_enable held with mem_address_select=1; retire in cycle 8.
- BEQ, alu_result_equal_zero=1 → cycle 3 pc_write_enable=1, next_pc_select=1, regfile_write_enable never 1. Repeat with zero=0 → next_pc_select=0.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH → fault=1 from cycle 6 on, all strobes 0. A reset pulse then returns to FETCH with fault=0.
- Opcode 1111111 → FAULT after DECODE, no retire. Reset asserted during MEM of an SW → data_mem_write_enable=0 next cycle, state=FETCH.
- With MULTICYCLE_MULDIV_EN, MUL (funct7=0000001) with muldiv_done after 5 cycles → single muldiv_start pulse, WRITEBACK retire in cycle 10.
